// File: rtl/mem_data_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: lock state encoding, reused
// by the debug interface to decode arbiter ownership.
package mem_data_arbiter_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_e;

endpackage : mem_data_arbiter_pkg

// File: rtl/mem_data_arbiter_if.sv
// Requester and memory bus bundle for mem_data_arbiter. The slave modport is
// the arbiter's view; the master modport is the requesters plus memory.
interface mem_data_arbiter_if #(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 10
);

  logic                  i_req0,    i_req1;
  logic                  i_we0,     i_we1;
  logic                  i_lock0,   i_lock1;
  logic [p_ADDR_LEN-1:0] i_addr0,   i_addr1;
  logic [p_WORD_LEN-1:0] i_wdata0,  i_wdata1;
  logic                  o_gnt0,    o_gnt1;
  logic                  o_rvalid0, o_rvalid1;
  logic [p_WORD_LEN-1:0] o_rdata0,  o_rdata1;
  logic                  o_lock_abort;
  logic                  o_mem_wr_en;
  logic [p_ADDR_LEN-1:0] o_mem_addr;
  logic [p_WORD_LEN-1:0] o_mem_wr_data;
  logic [p_WORD_LEN-1:0] i_mem_rd_data;

  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_lock0, i_lock1,
           i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rd_data,
    output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
           o_lock_abort, o_mem_wr_en, o_mem_addr, o_mem_wr_data
  );

  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_lock0, i_lock1,
           i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rd_data,
    input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
           o_lock_abort, o_mem_wr_en, o_mem_addr, o_mem_wr_data
  );

endinterface : mem_data_arbiter_if

// File: rtl/mem_data_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins; under contention the
// port that was not granted last wins.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,   // 1 = port 1 was granted last
  output logic gnt0_o,
  output logic gnt1_o
);

  assign gnt0_o = req0_i & (~req1_i |  last_i);
  assign gnt1_o = req1_i & (~req0_i | ~last_i);

endmodule : rr_pick2

// File: rtl/mem_data_arbiter.sv
// Arbitrates the single-port data memory between the core load/store port (0)
// and the DMA/debug port (1), with a bounded lock for atomic RMW sequences.
module mem_data_arbiter
  import mem_data_arbiter_pkg::*;
#(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 10,
  parameter int p_LOCK_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mem_data_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(p_LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(p_LOCK_MAX);

  lock_state_e           state_q, state_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  abort_q, abort_d;
  logic                  rvalid0_q, rvalid1_q;
  logic [p_WORD_LEN-1:0] rdata0_q, rdata1_q;
  logic                  pick0, pick1;
  logic                  gnt0, gnt1;
  logic                  gnt_lock;
  logic [p_ADDR_LEN-1:0] mem_addr;
  logic [p_WORD_LEN-1:0] mem_wr_data;

  rr_pick2 u_pick (
    .req0_i (bus.i_req0),
    .req1_i (bus.i_req1),
    .last_i (last_q),
    .gnt0_o (pick0),
    .gnt1_o (pick1)
  );

  // Saturating lock counter increment.
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign gnt_lock = gnt1 ? bus.i_lock1 : bus.i_lock0;

  // Grant decision and lock FSM next state.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;

    if (!i_rst) begin
      unique case (state_q)
        UNLOCKED: begin gnt0 = pick0;       gnt1 = pick1;       end
        LOCKED0:  begin gnt0 = bus.i_req0;                      end
        LOCKED1:  begin                     gnt1 = bus.i_req1;  end
        default:  ;
      endcase
    end

    if (gnt0 | gnt1) begin
      last_d = gnt1;
      if (gnt_lock) begin
        if (cnt_inc >= CNT_MAX) begin
          // Lock budget spent: force release; abort beats a re-lock request.
          state_d = UNLOCKED;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else begin
          state_d = gnt1 ? LOCKED1 : LOCKED0;
          cnt_d   = cnt_inc;
        end
      end else begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end
    end else if (state_q != UNLOCKED) begin
      // Owner dropped its request (or state is illegal): release the lock.
      state_d = UNLOCKED;
      cnt_d   = '0;
    end
  end

  // Memory bus mux: winner's address/data, port 0 when idle.
  always_comb begin
    mem_addr    = gnt1 ? bus.i_addr1  : bus.i_addr0;
    mem_wr_data = gnt1 ? bus.i_wdata1 : bus.i_wdata0;
  end

  // State, priority pointer, counter and registered read return.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q   <= UNLOCKED;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      rvalid0_q <= gnt0 & ~bus.i_we0;
      rvalid1_q <= gnt1 & ~bus.i_we1;
      if (gnt0 & ~bus.i_we0) rdata0_q <= bus.i_mem_rd_data;
      if (gnt1 & ~bus.i_we1) rdata1_q <= bus.i_mem_rd_data;
    end
  end

  assign bus.o_gnt0        = gnt0;
  assign bus.o_gnt1        = gnt1;
  assign bus.o_mem_wr_en   = (gnt0 & bus.i_we0) | (gnt1 & bus.i_we1);
  assign bus.o_mem_addr    = mem_addr;
  assign bus.o_mem_wr_data = mem_wr_data;
  assign bus.o_rvalid0     = rvalid0_q;
  assign bus.o_rvalid1     = rvalid1_q;
  assign bus.o_rdata0      = rdata0_q;
  assign bus.o_rdata1      = rdata1_q;
  assign bus.o_lock_abort  = abort_q;

endmodule : mem_data_arbiter

// File: tb/tb_mem_data_arbiter.sv
// Directed bench for mem_data_arbiter with a behavioural data memory that reads
// asynchronously and writes on the falling edge.
module tb_mem_data_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_data_arbiter_if #(.p_WORD_LEN(16), .p_ADDR_LEN(10)) bus ();

  mem_data_arbiter #(.p_WORD_LEN(16), .p_ADDR_LEN(10), .p_LOCK_MAX(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory model.
  logic [15:0] mem [1024];
  assign bus.i_mem_rd_data = mem[bus.o_mem_addr];
  always @(negedge clk) if (bus.o_mem_wr_en) mem[bus.o_mem_addr] <= bus.o_mem_wr_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic req, input logic we, input logic lock,
                        input logic [9:0] addr, input logic [15:0] wdata);
    bus.i_req0 = req; bus.i_we0 = we; bus.i_lock0 = lock;
    bus.i_addr0 = addr; bus.i_wdata0 = wdata;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic lock,
                        input logic [9:0] addr, input logic [15:0] wdata);
    bus.i_req1 = req; bus.i_we1 = we; bus.i_lock1 = lock;
    bus.i_addr1 = addr; bus.i_wdata1 = wdata;
  endtask

  task automatic do_reset();
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_p0(1, 1, 0, 10'h001, 16'h1111);
    set_p1(1, 0, 0, 10'h002, 16'h0);
    rst = 1'b1;
    step();
    #1;
    n_cmp++; if (bus.o_gnt0 !== 1'b0) begin n_bad++; $display("FAIL reset_gnt0: got %0b want 0", bus.o_gnt0); end
    n_cmp++; if (bus.o_gnt1 !== 1'b0) begin n_bad++; $display("FAIL reset_gnt1: got %0b want 0", bus.o_gnt1); end
    n_cmp++; if (bus.o_mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %0b want 0", bus.o_mem_wr_en); end
    n_cmp++; if ({bus.o_rvalid0, bus.o_rvalid1, bus.o_lock_abort} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {bus.o_rvalid0, bus.o_rvalid1, bus.o_lock_abort}); end
    n_cmp++; if ({bus.o_rdata0, bus.o_rdata1} !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", {bus.o_rdata0, bus.o_rdata1}); end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    set_p0(1, 1, 0, 10'd5, 16'h1234);
    #1;
    n_cmp++; if ({bus.o_gnt0, bus.o_mem_wr_en, bus.o_mem_addr} !== {2'b11, 10'd5}) begin n_bad++; $display("FAIL preload_write: got gnt0=%0b we=%0b addr=%h want 1 1 005", bus.o_gnt0, bus.o_mem_wr_en, bus.o_mem_addr); end
    step();
    set_p0(1, 0, 0, 10'd5, 16'h0);
    #1;
    n_cmp++; if ({bus.o_gnt0, bus.o_gnt1, bus.o_mem_wr_en} !== 3'b100) begin n_bad++; $display("FAIL read_grant: got %b want 100", {bus.o_gnt0, bus.o_gnt1, bus.o_mem_wr_en}); end
    step();
    set_p0(0, 0, 0, 0, 0);
    n_cmp++; if ({bus.o_rvalid0, bus.o_rvalid1} !== 2'b10) begin n_bad++; $display("FAIL read_rvalid: got %b want 10", {bus.o_rvalid0, bus.o_rvalid1}); end
    n_cmp++; if (bus.o_rdata0 !== 16'h1234) begin n_bad++; $display("FAIL read_rdata0: got %h want 1234", bus.o_rdata0); end
    step();
    n_cmp++; if (bus.o_rvalid0 !== 1'b0) begin n_bad++; $display("FAIL read_rvalid_drop: got %0b want 0", bus.o_rvalid0); end
    n_cmp++; if (bus.o_rdata0 !== 16'h1234) begin n_bad++; $display("FAIL read_retain: got %h want 1234", bus.o_rdata0); end
  endtask

  task automatic test_contention();
    logic exp_win [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    set_p0(1, 0, 0, 10'h010, 16'h0);
    set_p1(1, 0, 0, 10'h020, 16'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({bus.o_gnt0, bus.o_gnt1} !== {~exp_win[i], exp_win[i]}) begin n_bad++; $display("FAIL contention_gnt[%0d]: got %b want %b", i, {bus.o_gnt0, bus.o_gnt1}, {~exp_win[i], exp_win[i]}); end
      n_cmp++; if (bus.o_mem_addr !== (exp_win[i] ? 10'h020 : 10'h010)) begin n_bad++; $display("FAIL contention_addr[%0d]: got %h want %h", i, bus.o_mem_addr, exp_win[i] ? 10'h020 : 10'h010); end
      if (i > 0) begin
        n_cmp++; if ({bus.o_rvalid0, bus.o_rvalid1} !== {~exp_win[i-1], exp_win[i-1]}) begin n_bad++; $display("FAIL contention_rvalid[%0d]: got %b want %b", i, {bus.o_rvalid0, bus.o_rvalid1}, {~exp_win[i-1], exp_win[i-1]}); end
      end
      step();
    end
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
  endtask

  task automatic test_write_read();
    do_reset();
    set_p1(1, 1, 0, 10'h3FF, 16'hBEEF);
    #1;
    n_cmp++; if ({bus.o_gnt1, bus.o_mem_wr_en, bus.o_mem_addr, bus.o_mem_wr_data} !== {2'b11, 10'h3FF, 16'hBEEF}) begin n_bad++; $display("FAIL wr_cycle: got gnt1=%0b we=%0b addr=%h data=%h want 1 1 3ff beef", bus.o_gnt1, bus.o_mem_wr_en, bus.o_mem_addr, bus.o_mem_wr_data); end
    step();
    set_p1(1, 0, 0, 10'h3FF, 16'h0);
    #1;
    n_cmp++; if ({bus.o_gnt1, bus.o_mem_wr_en} !== 2'b10) begin n_bad++; $display("FAIL rd_cycle: got gnt1=%0b we=%0b want 1 0", bus.o_gnt1, bus.o_mem_wr_en); end
    step();
    set_p1(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if ({bus.o_rvalid1, bus.o_rdata1} !== {1'b1, 16'hBEEF}) begin n_bad++; $display("FAIL wr_rd_data: got v=%0b d=%h want 1 beef", bus.o_rvalid1, bus.o_rdata1); end
    n_cmp++; if (bus.o_mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL idle_wr_en: got %0b want 0", bus.o_mem_wr_en); end
  endtask

  task automatic test_lock_holdoff();
    logic locks [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    set_p1(1, 0, 0, 10'd4, 16'h0);
    for (int i = 0; i < 3; i++) begin
      set_p0(1, 0, locks[i], 10'(i + 1), 16'h0);
      #1;
      n_cmp++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b10) begin n_bad++; $display("FAIL holdoff[%0d]: got %b want 10", i, {bus.o_gnt0, bus.o_gnt1}); end
      step();
    end
    set_p0(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b01) begin n_bad++; $display("FAIL holdoff_release: got %b want 01", {bus.o_gnt0, bus.o_gnt1}); end
    step();
    set_p1(0, 0, 0, 0, 0);
  endtask

  task automatic test_lock_drop();
    do_reset();
    set_p1(1, 0, 1, 10'd7, 16'h0);
    #1;
    n_cmp++; if (bus.o_gnt1 !== 1'b1) begin n_bad++; $display("FAIL drop_lock_gnt1: got %0b want 1", bus.o_gnt1); end
    step();
    set_p1(0, 0, 0, 0, 0);
    set_p0(1, 0, 0, 10'd8, 16'h0);
    #1;
    n_cmp++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b00) begin n_bad++; $display("FAIL drop_holdoff: got %b want 00", {bus.o_gnt0, bus.o_gnt1}); end
    step();
    n_cmp++; if (bus.o_gnt0 !== 1'b1) begin n_bad++; $display("FAIL drop_after: got %0b want 1", bus.o_gnt0); end
    step();
    set_p0(0, 0, 0, 0, 0);
  endtask

  task automatic test_lock_timeout();
    do_reset();
    set_p0(1, 0, 1, 10'd9, 16'h0);
    set_p1(1, 0, 0, 10'd10, 16'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if ({bus.o_gnt0, bus.o_gnt1, bus.o_lock_abort} !== 3'b100) begin n_bad++; $display("FAIL timeout_hold[%0d]: got gnt0,gnt1,abort=%b want 100", i, {bus.o_gnt0, bus.o_gnt1, bus.o_lock_abort}); end
      step();
    end
    #1;
    n_cmp++; if ({bus.o_gnt0, bus.o_gnt1, bus.o_lock_abort} !== 3'b011) begin n_bad++; $display("FAIL timeout_abort: got gnt0,gnt1,abort=%b want 011", {bus.o_gnt0, bus.o_gnt1, bus.o_lock_abort}); end
    step();
    n_cmp++; if ({bus.o_gnt0, bus.o_gnt1, bus.o_lock_abort} !== 3'b100) begin n_bad++; $display("FAIL timeout_after: got gnt0,gnt1,abort=%b want 100", {bus.o_gnt0, bus.o_gnt1, bus.o_lock_abort}); end
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    set_p1(1, 0, 1, 10'd5, 16'h0);
    #1;
    n_cmp++; if (bus.o_gnt1 !== 1'b1) begin n_bad++; $display("FAIL rml_grant: got %0b want 1", bus.o_gnt1); end
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_gnt1 !== 1'b0) begin n_bad++; $display("FAIL rml_gnt_in_rst: got %0b want 0", bus.o_gnt1); end
    n_cmp++; if ({bus.o_rvalid1, bus.o_rdata1} !== {1'b1, 16'h1234}) begin n_bad++; $display("FAIL rml_prior_read: got v=%0b d=%h want 1 1234", bus.o_rvalid1, bus.o_rdata1); end
    step();
    rst = 1'b0;
    set_p0(1, 0, 0, 10'd6, 16'h0);
    #1;
    n_cmp++; if ({bus.o_rvalid1, bus.o_lock_abort} !== 2'b00) begin n_bad++; $display("FAIL rml_flags: got rvalid1,abort=%b want 00", {bus.o_rvalid1, bus.o_lock_abort}); end
    n_cmp++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b10) begin n_bad++; $display("FAIL rml_next_win: got %b want 10", {bus.o_gnt0, bus.o_gnt1}); end
    step();
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
  endtask

  initial begin
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_lock_holdoff();
    test_lock_drop();
    test_lock_timeout();
    test_reset_mid_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_mem_data_arbiter

// File: doc/mem_data_arbiter.md
# mem_data_arbiter

Two-port arbiter that shares the single-port data memory between the core's load/store port (port 0) and a DMA/debug port (port 1). It grants at most one access per cycle and muxes the winner's address, write enable and write data onto the memory bus. Read data is returned to the owning port one cycle later, registered. A bounded lock lets one port perform atomic read-modify-write sequences. It sits between the two requesters and the data memory. That memory reads asynchronously and writes on the falling clock edge.

## Interface
- p_WORD_LEN, 16, data word width
- p_ADDR_LEN, 10, address width
- p_LOCK_MAX, 8, maximum consecutive locked grants before forced release (≥1)

- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req0 / i_req1  in  1  access request, port 0 / port 1
- i_we0 / i_we1  in  1  1 = write, 0 = read
- i_lock0 / i_lock1  in  1  hold ownership after this access
- i_addr0 / i_addr1  in  p_ADDR_LEN  access address
- i_wdata0 / i_wdata1  in  p_WORD_LEN  write data
- o_gnt0 / o_gnt1  out  1  access accepted this cycle (combinational)
- o_rvalid0 / o_rvalid1  out  1  read data valid (registered)
- o_rdata0 / o_rdata1  out  p_WORD_LEN  read data (registered)
- o_lock_abort  out  1  one-cycle pulse when a lock is force-released
- o_mem_wr_en  out  1  memory write enable
- o_mem_addr  out  p_ADDR_LEN  memory address
- o_mem_wr_data  out  p_WORD_LEN  memory write data
- i_mem_rd_data  in  p_WORD_LEN  memory asynchronous read data

## Operation
- **State machine:** UNLOCKED, LOCKED0, LOCKED1.
- **Priority pointer:** r_last records the last granted port.
- **UNLOCKED, one requester:** it is granted.
- **UNLOCKED, both requesting:** the port ≠ r_last is granted (round-robin).
- **LOCKEDn:** only port n may be granted. The other port's request is held off with gnt = 0.
- **Granted access with i_lockN=1:** next state is LOCKEDn. Lock counter increments.
- **Granted access with i_lockN=0:** next state is UNLOCKED. Counter is cleared.
- **Owner drops i_reqN while in LOCKEDn:** lock is released. Next state is UNLOCKED and counter is cleared.
- **Counter reaches p_LOCK_MAX on a locked grant:** next state is UNLOCKED. o_lock_abort pulses next cycle. r_last = owner, so the other port wins the next contention.
- **On grant:** r_last is set to the granted port.
- **Memory mux:**
  - o_mem_addr/o_mem_wr_data come from the granted port.
  - With no grant they come from port 0.
  - o_mem_wr_en = gnt & we of the granted port; never 1 without a grant.
- **Read grant:** i_mem_rd_data is captured into o_rdataN at the rising edge. o_rvalidN=1 for exactly the following cycle.
- **Write grant:** the memory commits the data on the falling edge of the granted cycle. A read of the same address granted the next cycle returns the new data.
- **Data retention:** o_rdataN holds its last value when o_rvalidN=0.

## Timing
- **Grant:** combinational, same cycle as the request. A request is only consumed on a cycle with gnt=1; the requester holds req/addr/data until granted.
- **Read latency:** 1 cycle from grant to rvalid.
- **Throughput:** 1 access per cycle total.
- **Reset values:** state UNLOCKED, r_last=1 (port 0 wins first contention), counter 0, o_rvalid0/1=0, o_rdata0/1=0, o_lock_abort=0.
- **Combinational outputs during reset:** gnt outputs and o_mem_wr_en are 0 whenever i_rst=1.
- **Reset mid-lock:** the lock is dropped with no abort pulse.
- **Pending reads:** no rvalid follows a reset cycle.
- **Counter width:** $clog2(p_LOCK_MAX+1). The counter saturates rather than wrapping.
- **Simultaneous events:**
  - Owner's final unlocked access and the other port's request in the same cycle: the owner is granted that cycle; the other port is granted next cycle.
  - Abort and a new lock request from the same port: the abort wins.

## Structure
- State encoding localparams (UNLOCKED/LOCKED0/LOCKED1) go in a shared risc16 memory package, for reuse by the debug interface.
- One natural sub-module, rr_pick2: a 2-way round-robin selector (req0, req1, last → gnt0, gnt1).
- Lock FSM, counter, memory mux and read-data registers live in the top module.

## Test plan
- **Single read:** reset, then memory[5]=0x1234; port 0 reads addr 5 → gnt0=1 same cycle; o_rvalid0=1, o_rdata0=0x1234 next cycle; o_rvalid1 stays 0.
- **Contention after reset:** both ports request continuously for 4 cycles → grants alternate 0,1,0,1; o_mem_addr follows the winner each cycle.
- **Write then read:** port 1 writes 0xBEEF to addr 0x3FF, then reads it the next cycle → o_rdata1=0xBEEF; o_mem_wr_en=1 only in the write cycle.
- **Lock hold-off:** port 0 holds lock for 3 accesses (lock=1,1,0) while port 1 requests → gnt1=0 for those 3 cycles, gnt1=1 on the 4th.
- **Lock timeout:** with p_LOCK_MAX=8, port 0 holds lock=1 indefinitely while port 1 requests → 8 port-0 grants, o_lock_abort pulses once, then port 1 is granted.
- **Reset mid-lock:** assert i_rst during LOCKED1 with a pending read → next cycle o_rvalid1=0, state UNLOCKED, and port 0 wins the next contention.
